div_iter: RTL

Multi-cycle iterative radix-2 integer divider: the responder side of the EX-stage divide handshake. The ALU raises `en` for DIV/DIVU/MOD/MODU and stalls, holding operands and `is_signed` stable. This block computes quotient and remainder over 32 iterations, then pulses `complete` for one cycle; the ALU advances on `en && complete`. It replaces the single-cycle divide path and keeps the ALU's port contract unchanged.

---
 rtl/cpuDefine_pkg.sv | 15 +
 rtl/div_iter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cpuDefine_pkg.sv
// Shared CPU datapath types and the iterative divider's state encoding.
package cpuDefine;

  localparam int XLEN       = 32;
  localparam int DIV_CYCLES = XLEN + 1;

  typedef logic [XLEN-1:0] DType;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } DivState;

endpackage

// File: rtl/div_iter.sv
// Multi-cycle restoring radix-2 divider answering the ALU's en/complete divide handshake.
// Handshake: the ALU holds en high with stable operands; complete pulses for one cycle with results valid.
module div_iter
  import cpuDefine::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             complete,
  output DivState          dbg_state
);

  localparam int CW = $clog2(WIDTH);

  DivState          state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remr_q, remr_d;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // Partial remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, dvs_q});
    step_rem = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    remr_d  = remr_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          quo_d   = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
          dvs_d   = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
          qneg_d  = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d  = is_signed && dividend[WIDTH-1];
          dz_d    = (divisor == '0);
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == '0) begin
            // Zero divisor: the remainder path naturally rebuilds the original dividend.
            quot_d  = dz_q ? '1 : (qneg_q ? (~step_quo + 1'b1) : step_quo);
            remr_d  = rneg_q ? (~step_rem + 1'b1) : step_rem;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      remr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      remr_q  <= remr_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = remr_q;
  assign complete  = (state_q == DONE);
  assign dbg_state = state_q;

endmodule
